edge_event_arbiter: RTL

- Collects rising-edge events from `N_CH` level inputs and presents them, one at a time, to a single consumer over a valid/ready handshake.
- Each input has its own Moore edge detector and a pending flag; a round-robin scheduler shares the single event output fairly among the channels.
- Counts events lost to overflow.
- Sits between the synchronized switch/sensor inputs and the control FSM that services them.

---
 rtl/edge_arb_pkg.sv | 33 +++
 rtl/edge_pulse_chan.sv | 54 +++++
 rtl/edge_event_arbiter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/edge_arb_pkg.sv
// Shared types and the round-robin search helper for the edge event arbiter.
package edge_arb_pkg;

  typedef enum logic [1:0] {
    DET_LOW   = 2'd0,
    DET_PULSE = 2'd1,
    DET_HIGH  = 2'd2
  } det_state_t;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_OFFER = 1'b1
  } arb_state_t;

  // First set bit searching i_last+1, i_last+2, ... modulo i_n; returns i_last if none set.
  function automatic logic [3:0] rr_pick(input logic [15:0] i_pend,
                                         input logic [3:0]  i_last,
                                         input logic [4:0]  i_n);
    logic [4:0] idx;
    logic       found;
    rr_pick = i_last;
    found   = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      idx = 5'(i_last) + 5'(k);
      idx = (idx >= i_n) ? (idx - i_n) : idx;
      if (!found && (5'(k) <= i_n) && i_pend[idx[3:0]]) begin
        rr_pick = idx[3:0];
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/edge_pulse_chan.sv
// Moore rising-edge detector: one registered pulse per high period of i_in,
// including a line that is already high when reset is released.
module edge_pulse_chan
  import edge_arb_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_in,
  output logic o_pulse
);

  det_state_t r_state;

  // Detector state machine; the pulse is registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= DET_LOW;
      o_pulse <= 1'b0;
    end else begin
      case (r_state)
        DET_LOW: begin
          if (i_in) begin
            r_state <= DET_PULSE;
            o_pulse <= 1'b1;
          end else begin
            r_state <= DET_LOW;
            o_pulse <= 1'b0;
          end
        end
        DET_PULSE: begin
          o_pulse <= 1'b0;
          if (i_in) begin
            r_state <= DET_HIGH;
          end else begin
            r_state <= DET_LOW;
          end
        end
        DET_HIGH: begin
          o_pulse <= 1'b0;
          if (!i_in) begin
            r_state <= DET_LOW;
          end else begin
            r_state <= DET_HIGH;
          end
        end
        default: begin
          r_state <= DET_LOW;
          o_pulse <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/edge_event_arbiter.sv
// Collects per-channel rising edges into pending flags and offers them one at a
// time over valid/ready with round-robin fairness; counts events lost to overflow.
module edge_event_arbiter
  import edge_arb_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int DROP_W = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_CH-1:0]           i_in,
  input  logic [N_CH-1:0]           i_en,
  output logic                      o_evt_valid,
  input  logic                      i_evt_ready,
  output logic [$clog2(N_CH)-1:0]   o_evt_ch,
  output logic [N_CH-1:0]           o_pending,
  output logic [DROP_W-1:0]         o_drop_cnt,
  input  logic                      i_clr_drop
);

  localparam int CH_W  = $clog2(N_CH);
  localparam int CNT_W = $clog2(N_CH + 1);
  localparam int SUM_W = DROP_W + 5;

  logic [N_CH-1:0]   w_pulse;
  logic [N_CH-1:0]   w_pending_nxt;
  logic [CNT_W-1:0]  w_drop_n;
  logic [SUM_W-1:0]  w_drop_sum;
  logic [DROP_W-1:0] w_drop_sat;
  logic              w_accept;
  logic              w_hit;
  logic [CH_W-1:0]   w_pick;

  arb_state_t        r_arb;
  logic [CH_W-1:0]   r_last;
  logic [CH_W-1:0]   r_evt_ch;
  logic              r_evt_valid;
  logic [N_CH-1:0]   r_pending;
  logic [DROP_W-1:0] r_drop_cnt;

  for (genvar g = 0; g < N_CH; g++) begin : g_chan
    edge_pulse_chan u_chan (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_in   (i_in[g]),
      .o_pulse(w_pulse[g])
    );
  end

  assign w_accept = (r_arb == ARB_OFFER) && i_evt_ready;
  assign w_pick   = CH_W'(rr_pick(16'(r_pending), 4'(r_last), 5'(N_CH)));

  // Next pending flags and the number of events lost this cycle; a re-edge on
  // the channel being accepted re-arms its flag instead of counting as a drop.
  always_comb begin
    w_pending_nxt = r_pending;
    w_drop_n      = '0;
    w_hit         = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      w_hit = w_accept && (r_evt_ch == CH_W'(i));
      if (w_pulse[i] && i_en[i]) begin
        w_pending_nxt[i] = 1'b1;
        if (r_pending[i] && !w_hit) begin
          w_drop_n = w_drop_n + CNT_W'(1);
        end else begin
          w_drop_n = w_drop_n;
        end
      end else if (w_hit) begin
        w_pending_nxt[i] = 1'b0;
      end else begin
        w_pending_nxt[i] = r_pending[i];
      end
    end
  end

  // Saturating drop counter increment.
  always_comb begin
    w_drop_sum = SUM_W'(r_drop_cnt) + SUM_W'(w_drop_n);
    if (w_drop_sum > SUM_W'({DROP_W{1'b1}})) begin
      w_drop_sat = '1;
    end else begin
      w_drop_sat = w_drop_sum[DROP_W-1:0];
    end
  end

  // Pending flags, drop counter and the round-robin scheduler.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_arb       <= ARB_IDLE;
      r_last      <= CH_W'(N_CH - 1);
      r_evt_ch    <= '0;
      r_evt_valid <= 1'b0;
      r_pending   <= '0;
      r_drop_cnt  <= '0;
    end else begin
      r_pending <= w_pending_nxt;
      if (i_clr_drop) begin
        r_drop_cnt <= '0;
      end else begin
        r_drop_cnt <= w_drop_sat;
      end
      case (r_arb)
        ARB_IDLE: begin
          if (|r_pending) begin
            r_evt_ch    <= w_pick;
            r_evt_valid <= 1'b1;
            r_arb       <= ARB_OFFER;
          end else begin
            r_evt_valid <= 1'b0;
            r_arb       <= ARB_IDLE;
          end
        end
        ARB_OFFER: begin
          if (i_evt_ready) begin
            r_last      <= r_evt_ch;
            r_evt_valid <= 1'b0;
            r_arb       <= ARB_IDLE;
          end else begin
            r_evt_valid <= 1'b1;
            r_arb       <= ARB_OFFER;
          end
        end
        default: begin
          r_evt_valid <= 1'b0;
          r_arb       <= ARB_IDLE;
        end
      endcase
    end
  end

  assign o_evt_valid = r_evt_valid;
  assign o_evt_ch    = r_evt_ch;
  assign o_pending   = r_pending;
  assign o_drop_cnt  = r_drop_cnt;

endmodule
